// File: rtl/branch_station_if.sv
// Bundles the issue, CDB and result handshakes of the branch resolution station.
// master: the core side driving issue/CDB/grant. slave: the station.
interface branch_station_if #(
  parameter int unsigned TAG_W = 4
);
  // Issue port
  logic             issue_valid;
  logic [2:0]       issue_op;
  logic [31:0]      issue_pc;
  logic [31:0]      issue_rs1_val;
  logic [31:0]      issue_rs2_val;
  logic [TAG_W-1:0] issue_rs1_tag;
  logic [TAG_W-1:0] issue_rs2_tag;
  logic             issue_rs1_rdy;
  logic             issue_rs2_rdy;
  logic             issue_full;
  // Common data bus snoop
  logic             cdb_active_in;
  logic [TAG_W-1:0] cdb_tag_in;
  logic [31:0]      cdb_val_in;
  // Resolution result towards the CDB arbiter / predictor
  logic             br_req_out;
  logic             br_grant_in;
  logic [31:0]      br_addr_out;
  logic [31:0]      br_val_out;

  modport master (
    output issue_valid, issue_op, issue_pc, issue_rs1_val, issue_rs2_val,
    output issue_rs1_tag, issue_rs2_tag, issue_rs1_rdy, issue_rs2_rdy,
    output cdb_active_in, cdb_tag_in, cdb_val_in, br_grant_in,
    input  issue_full, br_req_out, br_addr_out, br_val_out
  );

  modport slave (
    input  issue_valid, issue_op, issue_pc, issue_rs1_val, issue_rs2_val,
    input  issue_rs1_tag, issue_rs2_tag, issue_rs1_rdy, issue_rs2_rdy,
    input  cdb_active_in, cdb_tag_in, cdb_val_in, br_grant_in,
    output issue_full, br_req_out, br_addr_out, br_val_out
  );
endinterface

// File: rtl/branch_station.sv
// In-order branch resolution station. Branches queue at issue, snoop the CDB for
// missing operands, and only the queue head may resolve so the predictor always
// sees outcomes in program order.
module branch_station #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned TAG_W   = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  branch_station_if.slave   bus
);

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      pc;
    logic [31:0]      v1;
    logic [TAG_W-1:0] t1;
    logic             r1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] t2;
    logic             r2;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH_W-1:0] front_q, front_d;
  logic [DEPTH_W-1:0] rear_q, rear_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        val_q, val_d;

  entry_t issue_ent;
  entry_t head;
  logic   push, pop, out_free;

  function automatic logic br_taken(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    logic res;
    case (op)
      3'b000:  res = (a == b);
      3'b001:  res = (a != b);
      3'b100:  res = ($signed(a) < $signed(b));
      3'b101:  res = !($signed(a) < $signed(b));
      3'b110:  res = (a < b);
      3'b111:  res = !(a < b);
      default: res = 1'b0;  // 010/011 are not branches; report not-taken
    endcase
    return res;
  endfunction

  assign bus.issue_full  = (count_q == (DEPTH_W + 1)'(DEPTH));
  assign bus.br_req_out  = req_q;
  assign bus.br_addr_out = addr_q;
  assign bus.br_val_out  = val_q;

  assign head     = ent_q[front_q];
  // Grant is only meaningful while a result is pending.
  assign out_free = !req_q || bus.br_grant_in;
  assign push     = bus.issue_valid && !bus.issue_full;
  // Operand readiness comes from registered state only: no CDB bypass into resolve.
  assign pop      = (count_q != '0) && head.r1 && head.r2 && out_free;

  // Build the incoming entry, capturing a same-cycle CDB broadcast for pending operands.
  always_comb begin
    issue_ent.op = bus.issue_op;
    issue_ent.pc = bus.issue_pc;
    issue_ent.v1 = bus.issue_rs1_val;
    issue_ent.t1 = bus.issue_rs1_tag;
    issue_ent.r1 = bus.issue_rs1_rdy;
    issue_ent.v2 = bus.issue_rs2_val;
    issue_ent.t2 = bus.issue_rs2_tag;
    issue_ent.r2 = bus.issue_rs2_rdy;
    if (bus.cdb_active_in && !bus.issue_rs1_rdy && bus.issue_rs1_tag == bus.cdb_tag_in) begin
      issue_ent.v1 = bus.cdb_val_in;
      issue_ent.r1 = 1'b1;
    end
    if (bus.cdb_active_in && !bus.issue_rs2_rdy && bus.issue_rs2_tag == bus.cdb_tag_in) begin
      issue_ent.v2 = bus.cdb_val_in;
      issue_ent.r2 = 1'b1;
    end
  end

  // Entry array next state: CDB snoop, head pop, tail push.
  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && bus.cdb_active_in) begin
        if (!ent_q[i].r1 && ent_q[i].t1 == bus.cdb_tag_in) begin
          ent_d[i].v1 = bus.cdb_val_in;
          ent_d[i].r1 = 1'b1;
        end
        if (!ent_q[i].r2 && ent_q[i].t2 == bus.cdb_tag_in) begin
          ent_d[i].v2 = bus.cdb_val_in;
          ent_d[i].r2 = 1'b1;
        end
      end
    end
    if (pop) begin
      valid_d[front_q] = 1'b0;
    end
    // Push never lands on the popped slot: that would need a full queue.
    if (push) begin
      ent_d[rear_q]   = issue_ent;
      valid_d[rear_q] = 1'b1;
    end
  end

  // Pointer, count and result register next state.
  always_comb begin
    front_d = pop  ? front_q + DEPTH_W'(1) : front_q;
    rear_d  = push ? rear_q + DEPTH_W'(1) : rear_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_W + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_W + 1)'(1);
      default: count_d = count_q;
    endcase
    req_d  = req_q;
    addr_d = addr_q;
    val_d  = val_q;
    if (pop) begin
      req_d  = 1'b1;
      addr_d = head.pc;
      val_d  = {31'b0, br_taken(head.op, head.v1, head.v2)};
    end else if (req_q && bus.br_grant_in) begin
      req_d = 1'b0;
    end
  end

  // State update: async reset, freeze while not ready, flush clears everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      valid_q <= '0;
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      val_q   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        valid_q <= '0;
        front_q <= '0;
        rear_q  <= '0;
        count_q <= '0;
        req_q   <= 1'b0;
        addr_q  <= '0;
        val_q   <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        valid_q <= valid_d;
        front_q <= front_d;
        rear_q  <= rear_d;
        count_q <= count_d;
        req_q   <= req_d;
        addr_q  <= addr_d;
        val_q   <= val_d;
      end
    end
  end

endmodule
